// File: rtl/uart_stim_tx.sv
// FIFO-fed UART frame transmitter with runtime baud divisor, parity, stop bits and inter-frame gap.
// Defining UART_STIM_BREAK_EN adds the brk_i port and a BREAK state for bootloader sync tests.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle; pop head word and latch config, or start a break
// S_START  | start bit (0) for one bit-time
// S_DATA   | DATA_W data bits, LSB first
// S_PARITY | even/odd parity bit
// S_STOP   | one or two stop bits (1); frame_done on the last cycle
// S_GAP    | idle bit-times after a frame
// S_BREAK  | line held low for DATA_W+2 bit-times (UART_STIM_BREAK_EN only)
module uart_stim_tx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_i,
  input  logic [DIV_W-1:0]              baud_div_i,
  input  logic [1:0]                    parity_i,
  input  logic                          stop2_i,
  input  logic [7:0]                    gap_i,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  input  logic [DATA_W-1:0]             wr_data_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          frame_done_o
`ifdef UART_STIM_BREAK_EN
  ,
  input  logic                          brk_i
`endif
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int BW    = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
`ifdef UART_STIM_BREAK_EN
    , S_BREAK
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [7:0]         gap_q, gap_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               par_en_q, par_en_d;
  logic               par_bit_q, par_bit_d;
  logic               stop2_q, stop2_d;
  logic               brk_q, brk_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];

  logic [LVL_W-1:0]   level;
  logic               full, empty, push, pop, bit_end;
  logic [DATA_W-1:0]  head;
  logic [DIV_W-1:0]   div_eff;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == LVL_W'(FIFO_DEPTH));
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign push    = wr_valid_i && !full;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign div_eff = (baud_div_i < DIV_W'(2)) ? DIV_W'(2) : baud_div_i;
  assign bit_end = (cnt_q == '0);

  assign wr_ptr_d = wr_ptr_q + LVL_W'(push);
  assign rd_ptr_d = rd_ptr_q + LVL_W'(pop);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    brk_d     = brk_q;
    pop       = 1'b0;
    done_d    = 1'b0;
    tx_d      = 1'b1;

    // Bit timer: reload div-1 on terminal count so every bit is exactly div clocks.
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? div_q - DIV_W'(1) : cnt_q - DIV_W'(1);
    end

    case (state_q)
      S_IDLE: begin
`ifdef UART_STIM_BREAK_EN
        if (brk_i) begin
          state_d = S_BREAK;
          div_d   = div_eff;
          cnt_d   = div_eff - DIV_W'(1);
          bit_d   = BW'(DATA_W + 1);
          brk_d   = 1'b1;
        end else
`endif
        if (!empty) begin
          pop       = 1'b1;
          state_d   = S_START;
          div_d     = div_eff;
          cnt_d     = div_eff - DIV_W'(1);
          shift_d   = head;
          par_en_d  = ^parity_i;
          par_bit_d = (^head) ^ (parity_i == 2'b10);
          stop2_d   = stop2_i;
          gap_d     = gap_i;
          brk_d     = 1'b0;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_W - 1)) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        tx_d = par_bit_q;
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (stop2_q && !brk_q && bit_q == '0) begin
            bit_d = BW'(1);
          end else begin
            done_d  = !brk_q;
            brk_d   = 1'b0;
            state_d = (gap_q != 8'd0 && !brk_q) ? S_GAP : S_IDLE;
          end
        end
      end
      S_GAP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (gap_q == 8'd1) state_d = S_IDLE;
          else               gap_d   = gap_q - 8'd1;
        end
      end
`ifdef UART_STIM_BREAK_EN
      S_BREAK: begin
        tx_d = 1'b0;
        if (bit_end) begin
          if (bit_q == '0) begin
            state_d = S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q - BW'(1);
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Line and done pulse are registered, so they trail the state by one clock.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      gap_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      brk_q     <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      brk_q     <= brk_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign wr_ready_o   = !full;
  assign tx_o         = tx_q;
  assign busy_o       = (state_q != S_IDLE) || !empty;
  assign level_o      = level;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_uart_stim_tx.sv
// Self-checking bench for uart_stim_tx: builds each expected frame waveform from the
// configured framing rules and compares the serial line cycle by cycle.
`timescale 1ns/1ps
module tb_uart_stim_tx;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int DIV_W      = 16;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;
  localparam int LIMIT      = 20000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DIV_W-1:0]  cfg_div = 16'd4;
  logic [1:0]        cfg_par = 2'b00;
  logic              cfg_stop2 = 1'b0;
  logic [7:0]        cfg_gap = 8'd0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic              tx, busy, frame_done;
  logic [LW-1:0]     level;
`ifdef UART_STIM_BREAK_EN
  logic              brk = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  uart_stim_tx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .sys_clk_i   (clk),
    .sys_rst_i   (rst),
    .baud_div_i  (cfg_div),
    .parity_i    (cfg_par),
    .stop2_i     (cfg_stop2),
    .gap_i       (cfg_gap),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .wr_data_i   (wr_data),
    .tx_o        (tx),
    .busy_o      (busy),
    .level_o     (level),
    .frame_done_o(frame_done)
`ifdef UART_STIM_BREAK_EN
    ,
    .brk_i       (brk)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  function automatic int eff_div();
    return (cfg_div < 2) ? 2 : int'(cfg_div);
  endfunction

  // Expected frame: start, data LSB first, optional parity, stop(s), then gap*div idle clocks.
  // wait_fall=0 means the frame must start right after exactly one idle clock.
  task automatic check_frame(input logic [DATA_W-1:0] w, input bit wait_fall, input string nm);
    logic exp_bits[$];
    int d, t, bad_bit, bad_fd, nb;
    logic got, req;
    d = eff_div();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) exp_bits.push_back(w[i]);
    if (cfg_par == 2'b01)      exp_bits.push_back(^w);
    else if (cfg_par == 2'b10) exp_bits.push_back(~^w);
    exp_bits.push_back(1'b1);
    if (cfg_stop2) exp_bits.push_back(1'b1);
    nb = exp_bits.size();
    bad_bit = -1; bad_fd = -1; got = 1'b0; req = 1'b0;
    if (wait_fall) begin
      t = 0;
      @(negedge clk);
      while (tx !== 1'b0 && t < LIMIT) begin @(negedge clk); t++; end
      if (tx !== 1'b0) begin
        checks++; errors++;
        $display("FAIL %s start_timeout tx=%b required=0", nm, tx);
        return;
      end
    end else begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin
        errors++;
        $display("FAIL %s idle_cycle tx=%b required=1", nm, tx);
      end
      @(negedge clk);
    end
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < d; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (tx !== exp_bits[b] && bad_bit < 0) begin bad_bit = b; got = tx; req = exp_bits[b]; end
        if (frame_done !== ((b == nb - 1) && (c == d - 1)) && bad_fd < 0) bad_fd = b * d + c;
      end
    end
    for (int g = 0; g < int'(cfg_gap) * d; g++) begin
      @(negedge clk);
      if (tx !== 1'b1 && bad_bit < 0) begin bad_bit = nb; got = tx; req = 1'b1; end
      if (frame_done !== 1'b0 && bad_fd < 0) bad_fd = nb * d + g;
    end
    checks++;
    if (bad_bit >= 0) begin
      errors++;
      $display("FAIL %s line word=%h bit=%0d tx=%b required=%b", nm, w, bad_bit, got, req);
    end
    checks++;
    if (bad_fd >= 0) begin
      errors++;
      $display("FAIL %s frame_done wrong at frame cycle %0d (required only at %0d)", nm, bad_fd, nb * d - 1);
    end
  endtask

  task automatic burst_frames(input logic [DATA_W-1:0] w [4], input string nm);
    fork
      begin
        @(negedge clk);
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
          wr_data = w[i];
          @(negedge clk);
        end
        wr_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 4; k++) check_frame(w[k], k == 0, nm);
      end
    join
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx tx=%b required=1", tx); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b required=1", wr_ready); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b required=0", busy); end
    checks++; if (level !== '0)      begin errors++; $display("FAIL reset_level got=%0d required=0", level); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b required=0", frame_done); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_8n1;
    cfg_div = 16'd868; cfg_par = 2'b00; cfg_stop2 = 1'b0; cfg_gap = 8'd0;
    @(negedge clk);
    wr_valid = 1'b1; wr_data = 8'h01;
    @(negedge clk);
    wr_valid = 1'b0;
    checks++;
    if (tx !== 1'b1 || level !== LW'(1) || busy !== 1'b1) begin
      errors++;
      $display("FAIL 8n1_after_write tx=%b level=%0d busy=%b required 1/1/1", tx, level, busy);
    end
    check_frame(8'h01, 1'b0, "8n1");
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || level !== '0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL 8n1_idle busy=%b level=%0d tx=%b required 0/0/1", busy, level, tx);
    end
  endtask

  task automatic test_burst;
    logic [DATA_W-1:0] w [4];
    logic [LW-1:0] lv [4];
    cfg_div = 16'd4; cfg_par = 2'b00; cfg_stop2 = 1'b0; cfg_gap = 8'd0;
    w[0] = 8'd1; w[1] = 8'd2; w[2] = 8'd3; w[3] = 8'd4;
    fork
      begin
        @(negedge clk);
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
          wr_data = w[i];
          @(negedge clk);
          lv[i] = level;
        end
        wr_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 4; k++) check_frame(w[k], k == 0, "burst");
      end
    join
    // The first word is popped the clock after it lands, so the level trails by one.
    checks++;
    if (lv[0] !== LW'(1) || lv[1] !== LW'(1) || lv[2] !== LW'(2) || lv[3] !== LW'(3)) begin
      errors++;
      $display("FAIL burst_level got=%0d,%0d,%0d,%0d required=1,1,2,3", lv[0], lv[1], lv[2], lv[3]);
    end
  endtask

  task automatic test_parity;
    logic [DATA_W-1:0] w [4];
    w[0] = 8'h07; w[1] = 8'h06; w[2] = 8'($urandom); w[3] = 8'($urandom);
    cfg_div = 16'd4; cfg_par = 2'b01; cfg_stop2 = 1'b1; cfg_gap = 8'd0;
    burst_frames(w, "even_2stop");
    cfg_par = 2'b10;
    burst_frames(w, "odd_2stop");
    cfg_par = 2'b11; cfg_stop2 = 1'b0;
    burst_frames(w, "par11_none");
  endtask

  task automatic test_random_cfg;
    logic [DATA_W-1:0] w [4];
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
      cfg_div   = DIV_W'($urandom_range(0, 6));
      cfg_par   = 2'($urandom_range(0, 3));
      cfg_stop2 = 1'($urandom_range(0, 1));
      cfg_gap   = 8'($urandom_range(0, 2));
      burst_frames(w, "random_cfg");
    end
  endtask

  task automatic test_full_gap;
    logic [DATA_W-1:0] w [10];
    int cyc, t, done_before;
    logic acc;
    for (int i = 0; i < 10; i++) w[i] = 8'($urandom);
    cfg_div = 16'd4; cfg_par = 2'b00; cfg_stop2 = 1'b0; cfg_gap = 8'd3;
    fork
      begin
        done_before = done_cnt;
        @(negedge clk);
        wr_valid = 1'b1;
        cyc = 0;
        for (int i = 0; i < 9 && cyc < 100; ) begin
          wr_data = w[i];
          acc = wr_ready;
          @(negedge clk);
          if (acc) i++;
          cyc++;
        end
        checks++;
        if (cyc !== 9) begin errors++; $display("FAIL full_fill_cycles got=%0d required=9", cyc); end
        checks++;
        if (level !== LW'(8) || wr_ready !== 1'b0) begin
          errors++;
          $display("FAIL full_state level=%0d ready=%b required 8/0", level, wr_ready);
        end
        wr_data = w[9];
        t = 0;
        acc = wr_ready;
        while (!acc && t < LIMIT) begin @(negedge clk); acc = wr_ready; t++; end
        @(negedge clk);
        wr_valid = 1'b0;
        checks++;
        if (!acc || done_cnt < done_before + 1 || level !== LW'(8)) begin
          errors++;
          $display("FAIL full_tenth accepted=%b frames_done=%0d level=%0d required 1/>=1/8",
                   acc, done_cnt - done_before, level);
        end
      end
      begin
        for (int k = 0; k < 10; k++) check_frame(w[k], k == 0, "full_gap3");
      end
    join
    cfg_gap = 8'd0;
  endtask

  task automatic test_reset_mid;
    int t, done_before, lows;
    cfg_div = 16'd4; cfg_par = 2'b00; cfg_stop2 = 1'b0; cfg_gap = 8'd0;
    @(negedge clk);
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'($urandom);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    t = 0;
    while (tx !== 1'b0 && t < LIMIT) begin @(negedge clk); t++; end
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL rstmid_start tx=%b required=0", tx); end
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || level !== '0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async tx=%b level=%0d busy=%b done=%b required 1/0/0/0",
               tx, level, busy, frame_done);
    end
    done_before = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    repeat (100) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    checks++;
    if (lows != 0 || done_cnt != done_before || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after low_cycles=%0d extra_done=%0d busy=%b required 0/0/0",
               lows, done_cnt - done_before, busy);
    end
  endtask

`ifdef UART_STIM_BREAK_EN
  task automatic test_break;
    int lows, t, done_before;
    logic [DATA_W-1:0] w;
    logic bad_hi;
    w = 8'($urandom);
    cfg_div = 16'd4; cfg_par = 2'b00; cfg_stop2 = 1'b0; cfg_gap = 8'd0;
    done_before = done_cnt;
    @(negedge clk);
    brk = 1'b1; wr_valid = 1'b1; wr_data = w;
    @(negedge clk);
    brk = 1'b0; wr_valid = 1'b0;
    t = 0;
    while (tx !== 1'b0 && t < 20) begin @(negedge clk); t++; end
    lows = 0;
    while (tx === 1'b0 && lows < 200) begin lows++; @(negedge clk); end
    checks++;
    if (lows != (DATA_W + 2) * 4) begin
      errors++;
      $display("FAIL break_low got=%0d clocks required=%0d", lows, (DATA_W + 2) * 4);
    end
    bad_hi = (tx !== 1'b1);
    repeat (3) begin @(negedge clk); if (tx !== 1'b1) bad_hi = 1'b1; end
    checks++;
    if (bad_hi || done_cnt != done_before) begin
      errors++;
      $display("FAIL break_stop line_low=%b done_pulses=%0d required 0/0", bad_hi, done_cnt - done_before);
    end
    check_frame(w, 1'b0, "after_break");
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_8n1();
    test_burst();
    test_parity();
    test_random_cfg();
    test_full_gap();
    test_reset_mid();
`ifdef UART_STIM_BREAK_EN
    test_break();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
